// File: rtl/design197_15_15_pkg.sv
// Shared widths and word/address types for the design197 lookup pipeline.
package design197_pkg;

  localparam int unsigned DW       = 32;
  localparam int unsigned AW       = 10;
  localparam int unsigned DEPTH    = 1024;
  localparam int unsigned N_STAGES = 18;

  typedef logic [DW-1:0] word_t;
  typedef logic [AW-1:0] addr_t;

endpackage

// File: rtl/design197_15_15_if.sv
// Word link between adjacent pipeline stages; the producing stage holds the master modport.
interface design197_15_15_if;
  import design197_pkg::*;

  word_t data;

  modport master (output data);
  modport slave  (input  data);

endinterface

// File: rtl/design197_15_15_memory_cntrl.sv
// One lookup stage: out <= d ^ mem[d[9:0]], with mem[d[9:0]] <= d when d[31] is set.
// D197_WRITE_FIRST_EN makes a writing stage read its own new value (output becomes 0).
module d197_ram
  import design197_pkg::*;
(
  input  logic  clk,
  input  logic  i_we,
  input  addr_t i_addr,
  input  word_t i_wdata,
  output word_t o_rdata
);

  // Storage name is referenced hierarchically for preloading.
  logic [DW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
  end

  assign o_rdata = mem[i_addr];

endmodule

module memory_cntrl
  import design197_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  design197_15_15_if.slave         i_d,
  design197_15_15_if.master        o_d
);

  word_t w_d;
  word_t w_rd;
  word_t w_lookup;
  addr_t w_addr;
  logic  w_we;
  word_t r_q;

  assign w_d    = i_d.data;
  assign w_addr = w_d[AW-1:0];
  assign w_we   = w_d[DW-1] & ~rst;

  d197_ram mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_d),
    .o_rdata (w_rd)
  );

`ifdef D197_WRITE_FIRST_EN
  assign w_lookup = w_d[DW-1] ? w_d : w_rd;
`else
  assign w_lookup = w_rd;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else     r_q <= w_d ^ w_lookup;
  end

  assign o_d.data = r_q;

endmodule

// File: rtl/design197_15_15.sv
// Eighteen chained memory_cntrl lookup stages; out is the last stage's register.
// Optional D197_WRITE_FIRST_EN selects write-first lookup inside each stage.
module design197_15_15
  import design197_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  word_t in,
  output word_t out
);

  design197_15_15_if w_link [0:N_STAGES] ();

  assign w_link[0].data = in;
  assign out            = w_link[N_STAGES].data;

  memory_cntrl memory_cntrl_instance101     (.clk(clk), .rst(rst), .i_d(w_link[0]),  .o_d(w_link[1]));
  memory_cntrl memory_cntrl_instance106     (.clk(clk), .rst(rst), .i_d(w_link[1]),  .o_d(w_link[2]));
  memory_cntrl memory_cntrl_instance214     (.clk(clk), .rst(rst), .i_d(w_link[2]),  .o_d(w_link[3]));
  memory_cntrl memory_cntrl_instance435     (.clk(clk), .rst(rst), .i_d(w_link[3]),  .o_d(w_link[4]));
  memory_cntrl memory_cntrl_instance760     (.clk(clk), .rst(rst), .i_d(w_link[4]),  .o_d(w_link[5]));
  memory_cntrl memory_cntrl_instance878     (.clk(clk), .rst(rst), .i_d(w_link[5]),  .o_d(w_link[6]));
  memory_cntrl memory_cntrl_instance4313    (.clk(clk), .rst(rst), .i_d(w_link[6]),  .o_d(w_link[7]));
  memory_cntrl memory_cntrl_instance5412    (.clk(clk), .rst(rst), .i_d(w_link[7]),  .o_d(w_link[8]));
  memory_cntrl memory_cntrl_instance8714    (.clk(clk), .rst(rst), .i_d(w_link[8]),  .o_d(w_link[9]));
  memory_cntrl memory_cntrl_instance9811    (.clk(clk), .rst(rst), .i_d(w_link[9]),  .o_d(w_link[10]));
  memory_cntrl memory_cntrl_instance9814    (.clk(clk), .rst(rst), .i_d(w_link[10]), .o_d(w_link[11]));
  memory_cntrl memory_cntrl_instance10096   (.clk(clk), .rst(rst), .i_d(w_link[11]), .o_d(w_link[12]));
  memory_cntrl memory_cntrl_instance120110  (.clk(clk), .rst(rst), .i_d(w_link[12]), .o_d(w_link[13]));
  memory_cntrl memory_cntrl_instance130121  (.clk(clk), .rst(rst), .i_d(w_link[13]), .o_d(w_link[14]));
  memory_cntrl memory_cntrl_instance150142  (.clk(clk), .rst(rst), .i_d(w_link[14]), .o_d(w_link[15]));
  memory_cntrl memory_cntrl_instance1101014 (.clk(clk), .rst(rst), .i_d(w_link[15]), .o_d(w_link[16]));
  memory_cntrl memory_cntrl_instance1201110 (.clk(clk), .rst(rst), .i_d(w_link[16]), .o_d(w_link[17]));
  memory_cntrl memory_cntrl_instance1401312 (.clk(clk), .rst(rst), .i_d(w_link[17]), .o_d(w_link[18]));

endmodule

// File: tb/tb_design197_15_15.sv
// Scoreboard bench for design197_15_15: each driven word is pushed through a model of the
// eighteen tables; a journal of model writes lets a mid-stream reset discard in-flight work.
module tb_design197_15_15;
  import design197_pkg::*;

  logic clk = 1'b0;
  logic rst;

  design197_15_15_if tb_in  ();
  design197_15_15_if tb_out ();

  design197_15_15 dut (
    .clk (clk),
    .rst (rst),
    .in  (tb_in.data),
    .out (tb_out.data)
  );

  always #5 clk = ~clk;

  typedef struct { int due; word_t val; } exp_t;
  typedef struct { int edge_n; int stg; int adr; word_t old; } jrn_t;

  exp_t  sb [$];
  jrn_t  jr [$];
  word_t mm [N_STAGES][DEPTH];
  int    checks   = 0;
  int    failures = 0;
  int    edge_cnt = 0;
  bit    need_bubbles = 1'b1;

  `define D197_ZERO(inst) for (int a = 0; a < 1024; a++) dut.inst.mem.mem[a] = '0;

  // Word entering stage 'start' at edge e_first; stage k sees it at e_first + (k - start).
  function automatic void model_word(input word_t w, input int start, input int e_first);
    word_t d;
    word_t rd;
    addr_t a;
    d = w;
    for (int k = start; k < N_STAGES; k++) begin
      a  = d[AW-1:0];
      rd = mm[k][a];
`ifdef D197_WRITE_FIRST_EN
      if (d[DW-1]) rd = d;
`endif
      if (d[DW-1]) begin
        jr.push_back('{e_first + k - start, k, int'(a), mm[k][a]});
        mm[k][a] = d;
      end
      d = d ^ rd;
    end
    sb.push_back('{e_first + (N_STAGES - 1 - start), d});
  endfunction

  // Undo model writes belonging to edges after the last edge before reset.
  function automatic void rollback(input int e);
    for (int i = jr.size() - 1; i >= 0; i--) begin
      if (jr[i].edge_n > e) begin
        mm[jr[i].stg][jr[i].adr] = jr[i].old;
        jr.delete(i);
      end
    end
  endfunction

  task automatic check_out(input string tag, input word_t exp);
    checks++;
    assert (tb_out.data === exp) else begin
      failures++;
      $error("FAIL %s: out=%h expected=%h (edge %0d)", tag, tb_out.data, exp, edge_cnt);
    end
  endtask

  task automatic check_mem(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: mem=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input word_t w, input logic r, input string tag);
    exp_t e;
    @(negedge clk);
    if (r && !rst) begin
      rollback(edge_cnt);
      sb.delete();
    end
    rst         = r;
    tb_in.data  = w;
    #1;
    if (r) check_out({tag, "_async"}, '0);
    @(posedge clk);
    edge_cnt++;
    if (r) need_bubbles = 1'b1;
    else begin
      // Cleared stage registers re-enter stages 1..17 as zero words.
      if (need_bubbles) begin
        for (int j = N_STAGES - 1; j >= 1; j--) model_word('0, j, edge_cnt);
        need_bubbles = 1'b0;
      end
      model_word(w, 0, edge_cnt);
    end
    #1;
    if (r) check_out({tag, "_hold"}, '0);
    else if (sb.size() > 0 && sb[0].due == edge_cnt) begin
      e = sb.pop_front();
      check_out(tag, e.val);
    end else begin
      checks++;
      failures++;
      $error("FAIL %s_sb: no expectation for edge %0d, out=%h", tag, edge_cnt, tb_out.data);
    end
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: time limit reached, out=%h", tb_out.data);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    word_t keep;
    rst        = 1'b1;
    tb_in.data = '0;
    for (int k = 0; k < N_STAGES; k++)
      for (int a = 0; a < DEPTH; a++) mm[k][a] = '0;
    `D197_ZERO(memory_cntrl_instance101)
    `D197_ZERO(memory_cntrl_instance106)
    `D197_ZERO(memory_cntrl_instance214)
    `D197_ZERO(memory_cntrl_instance435)
    `D197_ZERO(memory_cntrl_instance760)
    `D197_ZERO(memory_cntrl_instance878)
    `D197_ZERO(memory_cntrl_instance4313)
    `D197_ZERO(memory_cntrl_instance5412)
    `D197_ZERO(memory_cntrl_instance8714)
    `D197_ZERO(memory_cntrl_instance9811)
    `D197_ZERO(memory_cntrl_instance9814)
    `D197_ZERO(memory_cntrl_instance10096)
    `D197_ZERO(memory_cntrl_instance120110)
    `D197_ZERO(memory_cntrl_instance130121)
    `D197_ZERO(memory_cntrl_instance150142)
    `D197_ZERO(memory_cntrl_instance1101014)
    `D197_ZERO(memory_cntrl_instance1201110)
    `D197_ZERO(memory_cntrl_instance1401312)
    #1;
    check_out("reset_t0", '0);

    repeat (2)  step('0, 1'b1, "reset");
    repeat (20) step('0, 1'b0, "idle");

    step(32'h0000_0005, 1'b0, "pass_in");
    repeat (20) step('0, 1'b0, "pass");

    step(32'h8000_0005, 1'b0, "wr_in");
    repeat (30) step('0, 1'b0, "wr_gap");
    check_mem("mem0_5", dut.memory_cntrl_instance101.mem.mem[5], mm[0][5]);
    step(32'h0000_0005, 1'b0, "hit_in");
    repeat (20) step('0, 1'b0, "hit");

    repeat (2)  step('0, 1'b1, "reset2");
    step(32'hFFFF_FFFF, 1'b0, "ones_in");
    repeat (20) step('0, 1'b0, "ones");
    check_mem("mem0_3ff", dut.memory_cntrl_instance101.mem.mem[10'h3FF], mm[0][10'h3FF]);

    for (int i = 0; i < 60; i++) step($urandom, 1'b0, "rand_a");
    keep = $urandom | 32'h8000_0000;
    step(keep, 1'b0, "rand_keep");
    repeat (3)  step($urandom, 1'b0, "rand_b");
    step($urandom, 1'b1, "mid_rst");
    check_mem("mem0_kept", dut.memory_cntrl_instance101.mem.mem[keep[AW-1:0]], mm[0][keep[AW-1:0]]);
    for (int i = 0; i < 40; i++) step($urandom, 1'b0, "rand_c");
    repeat (20) step('0, 1'b0, "drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/design197_15_15.md
# design197_15_15

Eighteen-stage pipeline of 1024×32 memory controllers that transforms a 32-bit input word into a 32-bit output word. Each stage does a table lookup and an optional table update, then passes the result to the next stage. The block is the core of `design197_15_15_top`, which instantiates it as `design197_15_15_inst` and connects `clk`, `rst`, `in` and `out` straight through. Post-synthesis and post-route netlists are checked against this RTL cycle by cycle.

## Interface
- `DW`, 32: data width.
- `AW`, 10: memory address width (depth 1024).
- `N_STAGES`, 18: number of memory_cntrl stages.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `in  in  32`: input word, sampled every rising edge.
- `out  out  32`: registered output of the last stage.

## Operation
- Stage k receives word d_k; d_0 = `in`, d_{k+1} = output register of stage k, `out` = output register of stage 17.
- Per stage, every rising edge with `rst`=0:
  - a = d_k[9:0].
  - Output register <= d_k XOR mem_k[a], using the pre-write contents of mem_k[a].
  - If d_k[31]=1, mem_k[a] <= d_k.
- Memories are not cleared by reset. Their contents are zero at time 0 through initialisation, and the bench may also preload them hierarchically.
- Stage chain order, by instance name memory_cntrl_instance<id>, with id in this order: 101, 106, 214, 435, 760, 878, 4313, 5412, 8714, 9811, 9814, 10096, 120110, 130121, 150142, 1101014, 1201110, 1401312.
- Arithmetic is bitwise only. There is no carry and no width growth.
- Address wrap: the address is always d[9:0], so there is no out-of-range case.

## Timing
- Latency is 18 cycles from `in` to `out`. Throughput is one word per cycle, and there is no handshake.
- Reset: all 18 stage output registers, and therefore `out`, clear to 0 immediately on `rst`=1. Writes to memory are suppressed while `rst`=1.
- Reset asserted mid-stream:
  - words in flight are lost;
  - memory contents written before reset are retained;
  - after release, the first `in` sample appears on `out` 18 edges later.
- Same-stage read/write to the same address in one cycle: the read returns the old data (read-before-write) unless D197_WRITE_FIRST_EN is defined.

## Configuration
- `D197_WRITE_FIRST_EN`:
  - Defined: a stage that writes mem_k[a] this cycle uses the new value d_k for the read. The output register therefore becomes 0 when d_k[31]=1.
  - Undefined (default): read-before-write as described above. The netlists are built with it undefined.

## Structure
- Package `design197_pkg` holds:
  - DW, AW, DEPTH=1024 and N_STAGES=18;
  - the typedefs `word_t` (logic [31:0]) and `addr_t` (logic [9:0]).
- Sub-module `memory_cntrl` (one per stage) holds:
  - the lookup/XOR/output register logic;
  - a RAM instance named `mem` whose storage array is named `mem` (`logic [31:0] mem [0:1023]`). This exact name is required so the bench can preload it by hierarchical path.
- Top `design197_15_15` generates the 18 instances with the names listed in Operation.

## Test plan
- Reset: `rst`=1 for 2 cycles with `in`=0 → `out`=0 during reset and for 18 cycles after release; `out`=0 thereafter while `in`=0.
- Passthrough, no write: memories zeroed, one word `in`=0x0000_0005 then zeros → `out`=0x0000_0005 exactly 18 cycles later, 0 on all other cycles.
- Write then hit:
  - `in`=0x8000_0005 for one cycle, then 0x0000_0000 for 30 cycles, then 0x0000_0005 → `out` shows 0x8000_0005 at +18 cycles;
  - when the 0x0000_0005 word leaves stage 0 it becomes 0x8000_0000 (it hit mem_0[5]).
- Corner: after reset, apply `in`=0xFFFF_FFFF for one cycle → `out`=0xFFFF_FFFF 18 cycles later. Stage 0 mem_0[0x3FF] reads back 0xFFFF_FFFF.
- Random: 100 cycles of `$urandom` input, compared every cycle against the post-synth and post-route netlists → zero mismatches.
- Reset mid-stream: assert `rst` for 1 cycle during random traffic → `out`=0 at once. Words written to memory before reset still affect results after release.
